seg_scroll_ctrl: RTL and testbench

- Bus-mapped controller that scrolls a message of up to 8 digit codes across the four-digit seven-segment peripheral at 0xD0–0xD3.
- Acts as a slave for configuration on the processor bus.
- Acts as a second bus master: requests the bus, then issues a 4-write burst to the display registers on every scroll tick.
- Sits beside the processor; the system bus mux selects master outputs from the grant.

---
 rtl/seg_scroll_ctrl_pkg.sv | 29 ++
 rtl/seg_scroll_tick.sv | 36 +++
 rtl/seg_scroll_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scroll_ctrl_pkg.sv
// Shared constants for the seven-segment scroll controller: register offsets,
// CTRL bit positions, FSM encoding and the message length limit.
package seg_scroll_ctrl_pkg;

  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_LEN  = 4'h1;
  localparam logic [3:0] OFF_RATE = 4'h2;
  localparam logic [3:0] OFF_PTR  = 4'h3;
  localparam logic [3:0] OFF_MSG  = 4'h8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 6;
  localparam int CTRL_BUSY = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int MAX_LEN = 8;

  // Zero behaves as one digit; anything beyond the message buffer is clamped.
  function automatic logic [3:0] len_eff(input logic [3:0] len);
    if (len == 4'd0) return 4'd1;
    if (len > 4'(MAX_LEN)) return 4'(MAX_LEN);
    return len;
  endfunction

endpackage

// File: rtl/seg_scroll_tick.sv
// Scroll step generator: a prescaler producing rate units and a rate counter
// that emits a one-cycle step pulse every rate_eff units.
module seg_scroll_tick #(
  parameter logic [16:0] PRESCALE = 17'd100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] rate_eff,
  output logic       step
);

  logic [16:0] pre_cnt;
  logic [7:0]  rate_cnt;
  logic [8:0]  rate_next;
  logic        wrap;

  assign wrap      = (pre_cnt == PRESCALE - 17'd1);
  assign rate_next = {1'b0, rate_cnt} + 9'd1;
  // >= rather than == so that lowering RATE on the fly cannot strand the counter.
  assign step      = en && wrap && (rate_next >= {1'b0, rate_eff});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      rate_cnt <= '0;
    end else if (!en) begin
      pre_cnt  <= '0;
      rate_cnt <= '0;
    end else begin
      pre_cnt <= wrap ? 17'd0 : pre_cnt + 17'd1;
      if (wrap) rate_cnt <= step ? 8'd0 : rate_next[7:0];
    end
  end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Bus-mapped scroll controller: configured as a bus slave, and as a second bus
// master it pushes four message digits to the display registers on each step.
module seg_scroll_ctrl
  import seg_scroll_ctrl_pkg::*;
#(
  parameter logic [7:0]  SEG_BASE = 8'hD0,
  parameter logic [7:0]  CFG_BASE = 8'hE0,
  parameter logic [16:0] PRESCALE = 17'd100000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       M_REQ,
  input  logic       M_GNT,
  output logic [7:0] M_ADDR,
  output logic [7:0] M_DATA,
  output logic       M_WE
);

  logic       en;
  logic [3:0] len;
  logic [7:0] rate;
  logic [2:0] ptr;
  logic [7:0] msg [MAX_LEN];
  logic       pend;
  logic [1:0] state;
  logic [1:0] k;
  logic [7:0] rd_data;
  logic [7:0] rd_value;
  logic       rd_drive;

  logic [3:0] off;
  logic       hit, wr_hit, rd_hit;
  logic       en_next, en_rise, tick_step, start, go, busy;
  logic [3:0] len_e;
  logic [7:0] rate_e;
  logic [2:0] digit_idx;
  logic [2:0] next_ptr;

  assign off     = BUS_ADDR[3:0];
  assign hit     = (BUS_ADDR[7:4] == CFG_BASE[7:4]);
  assign wr_hit  = hit && BUS_WE;
  assign rd_hit  = hit && !BUS_WE;
  assign en_next = (wr_hit && off == OFF_CTRL) ? BUS_DATA[CTRL_EN] : en;
  assign en_rise = en_next && !en;
  assign start   = tick_step || en_rise;
  // A step landing on the same cycle EN is cleared must not launch a burst.
  assign go      = en_next && (start || pend);
  assign busy    = (state != ST_IDLE);
  assign len_e   = len_eff(len);
  assign rate_e  = (rate == 8'd0) ? 8'd1 : rate;

  assign digit_idx = 3'(({1'b0, ptr} + {2'b00, k}) % len_e);
  assign next_ptr  = 3'(({1'b0, ptr} + 4'd1) % len_e);

  seg_scroll_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .en       (en),
    .rate_eff (rate_e),
    .step     (tick_step)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      en   <= 1'b0;
      len  <= '0;
      rate <= '0;
      for (int i = 0; i < MAX_LEN; i++) msg[i] <= '0;
    end else if (wr_hit) begin
      case (off)
        OFF_CTRL: en   <= BUS_DATA[CTRL_EN];
        OFF_LEN:  len  <= BUS_DATA[3:0];
        OFF_RATE: rate <= BUS_DATA;
        default:  if (off[3]) msg[off[2:0]] <= BUS_DATA;
      endcase
    end
  end

  always_comb begin
    rd_value = '0;
    case (off)
      OFF_CTRL: begin
        rd_value[CTRL_BUSY] = busy;
        rd_value[CTRL_PEND] = pend;
        rd_value[CTRL_EN]   = en;
      end
      OFF_LEN:  rd_value = {4'b0000, len};
      OFF_RATE: rd_value = rate;
      OFF_PTR:  rd_value = {5'b00000, ptr};
      default:  if (off[3]) rd_value = msg[off[2:0]];
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_data  <= '0;
      rd_drive <= 1'b0;
    end else begin
      rd_drive <= rd_hit;
      if (rd_hit) rd_data <= rd_value;
    end
  end

  assign BUS_DATA = rd_drive ? rd_data : 8'bz;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      k     <= '0;
      ptr   <= '0;
      pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (go) state <= ST_REQ;
        ST_REQ: if (M_GNT) begin
          state <= ST_WR;
          k     <= 2'd0;
        end
        ST_WR: if (M_GNT) begin
          if (k == 2'd3) state <= ST_DONE;
          else           k     <= k + 2'd1;
        end
        default: begin
          ptr   <= next_ptr;
          state <= ST_IDLE;
        end
      endcase
      if (!busy)      pend <= 1'b0;
      else if (start) pend <= 1'b1;
      if (!en_next)   pend <= 1'b0;
      if (en_rise)    ptr  <= '0;
    end
  end

  always_comb begin
    M_REQ  = (state == ST_REQ) || (state == ST_WR);
    M_WE   = 1'b0;
    M_ADDR = '0;
    M_DATA = '0;
    if (state == ST_WR) begin
      M_WE   = M_GNT;
      M_ADDR = SEG_BASE + {6'b000000, k};
      M_DATA = msg[digit_idx];
    end
  end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Bench for seg_scroll_ctrl: a transaction-level model of the scrolled digits
// checked on every master write, plus directed scenarios with literal values.
module tb_seg_scroll_ctrl;

  localparam logic [16:0] PS = 17'd4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] busAddr = 8'h00;
  logic       busWe = 1'b0;
  logic       tbOe = 1'b0;
  logic [7:0] tbWdata = 8'h00;
  logic       mGnt = 1'b0;
  logic       mReq, mWe;
  logic [7:0] mAddr, mData;
  wire  [7:0] busData;

  assign busData = tbOe ? tbWdata : 8'bz;

  // A released bus floats high so "not driven" is observable as 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pullup
    pullup (busData[i]);
  end

  seg_scroll_ctrl #(.SEG_BASE(8'hD0), .CFG_BASE(8'hE0), .PRESCALE(PS)) dut (
    .CLK      (clk),
    .RESET_N  (rstN),
    .BUS_DATA (busData),
    .BUS_ADDR (busAddr),
    .BUS_WE   (busWe),
    .M_REQ    (mReq),
    .M_GNT    (mGnt),
    .M_ADDR   (mAddr),
    .M_DATA   (mData),
    .M_WE     (mWe)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wlog[$];
  int         cyc = 0;
  logic [7:0] mMsg [8];
  logic [3:0] mLen;
  logic       mEn;
  int         mPtr;
  int         mK;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic int leff(input logic [3:0] l);
    if (l == 4'd0) return 1;
    if (l > 4'd8) return 8;
    return int'(l);
  endfunction

  task automatic modelReset();
    mLen = 4'd0;
    mEn  = 1'b0;
    mPtr = 0;
    mK   = 0;
    for (int i = 0; i < 8; i++) mMsg[i] = 8'h00;
  endtask

  // One bus cycle; the model tracks every configuration write the bench makes.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data, input logic we);
    busAddr = addr;
    busWe   = we;
    tbWdata = data;
    tbOe    = we;
    @(posedge clk);
    #1;
    busAddr = 8'h00;
    busWe   = 1'b0;
    tbOe    = 1'b0;
    if (we && addr[7:4] == 4'hE) begin
      if (addr[3:0] == 4'h0) begin
        if (data[0] && !mEn) begin
          mPtr = 0;
          mK   = 0;
        end
        mEn = data[0];
      end else if (addr[3:0] == 4'h1) begin
        mLen = data[3:0];
      end else if (addr[3]) begin
        mMsg[addr[2:0]] = data;
      end
    end
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [7:0] data);
    applyStimulus(addr, 8'h00, 1'b0);
    @(negedge clk);
    data = busData;
  endtask

  task automatic waitWrites(input int n, input int budget);
    int t = 0;
    while (wlog.size() < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    checkOutput("write_count_reached", 32'(wlog.size() >= n), 32'd1);
  endtask

  // Every master write must carry the next digit of the scrolled message.
  always @(negedge clk) begin
    cyc++;
    if (rstN) begin
      if (mWe) begin
        checkOutput("wr_addr", mAddr, 32'(8'hD0 + 8'(mK)));
        checkOutput("wr_data", mData, mMsg[(mPtr + mK) % leff(mLen)]);
        checkOutput("we_with_req_gnt", {mReq, mGnt}, 32'd3);
        wlog.push_back('{mAddr, mData, cyc});
        mK++;
        if (mK == 4) begin
          mK   = 0;
          mPtr = (mPtr + 1) % leff(mLen);
        end
      end else if (!mReq) begin
        checkOutput("idle_outputs_zero", {mAddr, mData}, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [7:0] rd;
    int n0, t, mp, reqs;
    logic [7:0] expD [16];
    expD = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h11, 8'h12, 8'h13, 8'h14,
             8'h12, 8'h13, 8'h14, 8'h15, 8'h13, 8'h14, 8'h15, 8'h10};
    modelReset();

    // Reset state and bus release
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset_m_req", mReq, 0);
    checkOutput("reset_m_we", mWe, 0);
    checkOutput("reset_m_addr", mAddr, 0);
    checkOutput("bus_z_before_read", busData, 8'hFF);
    busRead(8'hE0, rd);
    checkOutput("reset_ctrl", rd, 8'h00);
    @(posedge clk);
    #1;
    busAddr = 8'hE4;
    busWe   = 1'b1;
    @(negedge clk);
    checkOutput("bus_z_during_we", busData, 8'hFF);
    @(posedge clk);
    #1;
    busAddr = 8'h00;
    busWe   = 1'b0;
    @(negedge clk);
    checkOutput("bus_z_after_we", busData, 8'hFF);
    busRead(8'hE3, rd);
    checkOutput("reset_ptr", rd, 8'h00);
    applyStimulus(8'hE5, 8'h5A, 1'b1);
    busRead(8'hE5, rd);
    checkOutput("unmapped_reads_zero", rd, 8'h00);

    // Basic scrolling, LEN=6 RATE=2
    mGnt = 1'b1;
    applyStimulus(8'hE1, 8'd6, 1'b1);
    applyStimulus(8'hE2, 8'd2, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(8'hE8 + 8'(i), 8'h10 + 8'(i), 1'b1);
    busRead(8'hE9, rd);
    checkOutput("msg1_readback", rd, 8'h11);
    busRead(8'hE1, rd);
    checkOutput("len_readback", rd, 8'h06);
    applyStimulus(8'hE0, 8'h01, 1'b1);
    waitWrites(16, 200);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("burst_data_%0d", i), wlog[i].data, expD[i]);
      checkOutput($sformatf("burst_addr_%0d", i), wlog[i].addr, 32'(8'hD0 + 8'(i % 4)));
    end
    for (int b = 1; b < 4; b++)
      checkOutput($sformatf("burst_interval_%0d", b), 32'(wlog[4*b].cyc - wlog[4*(b-1)].cyc), 32'd8);

    // Grant dropped for 5 cycles after the second write of burst 5
    waitWrites(18, 100);
    @(posedge clk);
    #1;
    mGnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("held_no_we", mWe, 0);
      checkOutput("held_addr", mAddr, 8'hD2);
      checkOutput("held_req", mReq, 1);
      @(posedge clk);
      #1;
    end
    mGnt = 1'b1;
    waitWrites(20, 50);
    checkOutput("resume_d2_addr", wlog[18].addr, 8'hD2);
    checkOutput("resume_d2_data", wlog[18].data, 8'h10);
    checkOutput("resume_d3_data", wlog[19].data, 8'h11);
    checkOutput("resume_gap", 32'(wlog[18].cyc - wlog[17].cyc), 32'd6);

    // Grant withheld across several steps: exactly one pending burst follows
    t = 0;
    while (!(wlog.size() >= 24 && wlog.size() % 4 == 0) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    checkOutput("sync_burst_end", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1;
    mGnt = 1'b0;
    n0 = wlog.size();
    repeat (30) @(posedge clk);
    #1;
    busRead(8'hE0, rd);
    checkOutput("ctrl_busy_pend", rd, 8'hC1);
    @(posedge clk);
    #1;
    applyStimulus(8'hE2, 8'd200, 1'b1);
    mGnt = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("pend_one_burst", 32'(wlog.size() - n0), 32'd8);
    busRead(8'hE0, rd);
    checkOutput("ctrl_drained", rd, 8'h01);

    // LEN=0 behaves as a single digit
    @(posedge clk);
    #1;
    applyStimulus(8'hE0, 8'h00, 1'b1);
    applyStimulus(8'hE1, 8'h00, 1'b1);
    applyStimulus(8'hE8, 8'h07, 1'b1);
    applyStimulus(8'hE0, 8'h01, 1'b1);
    n0 = wlog.size();
    waitWrites(n0 + 4, 50);
    for (int i = 0; i < 4; i++) checkOutput("len0_digit", wlog[n0 + i].data, 8'h07);
    repeat (4) @(posedge clk);
    #1;
    busRead(8'hE3, rd);
    checkOutput("len0_ptr", rd, 8'h00);

    // LEN=12 clamps to 8; continuous bursts with RATE=1
    @(posedge clk);
    #1;
    applyStimulus(8'hE0, 8'h00, 1'b1);
    applyStimulus(8'hE1, 8'd12, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(8'hE8 + 8'(i), 8'h20 + 8'(i), 1'b1);
    applyStimulus(8'hE2, 8'd1, 1'b1);
    applyStimulus(8'hE0, 8'h01, 1'b1);
    n0 = wlog.size();
    waitWrites(n0 + 36, 400);
    checkOutput("len12_b6_k2", wlog[n0 + 26].data, 8'h20);
    checkOutput("len12_b7_k0", wlog[n0 + 28].data, 8'h27);
    checkOutput("len12_b8_k0", wlog[n0 + 32].data, 8'h20);

    // EN cleared during WR k=1: burst completes, PTR advances once
    t = 0;
    while (wlog.size() % 4 != 1 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    checkOutput("sync_k0", 32'(t < 50), 32'd1);
    mp = mPtr;
    n0 = wlog.size() - 1;
    @(posedge clk);
    #1;
    applyStimulus(8'hE0, 8'h00, 1'b1);
    waitWrites(n0 + 4, 20);
    reqs = 0;
    repeat (40) begin
      @(negedge clk);
      if (mReq) reqs++;
    end
    checkOutput("no_req_after_en_clear", reqs, 0);
    checkOutput("writes_after_en_clear", 32'(wlog.size() - n0), 32'd4);
    busRead(8'hE3, rd);
    checkOutput("ptr_advanced_once", rd, 32'((mp + 1) % 8));
    busRead(8'hE0, rd);
    checkOutput("ctrl_after_en_clear", rd, 8'h00);

    // Asynchronous reset mid-burst
    @(posedge clk);
    #1;
    n0 = wlog.size();
    applyStimulus(8'hE0, 8'h01, 1'b1);
    waitWrites(n0 + 1, 20);
    checkOutput("pre_reset_we", mWe, 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_req", mReq, 0);
    checkOutput("async_reset_we", mWe, 0);
    checkOutput("async_reset_addr", mAddr, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    busRead(8'hE0, rd);
    checkOutput("post_reset_ctrl", rd, 8'h00);
    busRead(8'hE8, rd);
    checkOutput("post_reset_msg0", rd, 8'h00);
    busRead(8'hE1, rd);
    checkOutput("post_reset_len", rd, 8'h00);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
